// File: rtl/sound_frame_sequencer.sv
// sound_frame_sequencer: 512 Hz frame sequencer producing length/sweep/envelope ticks
// and per-channel length counters that gate sound channel activity.
module sound_frame_sequencer #(
   parameter int DIVIDER = 8192
) (
   input  logic       I_CLK,
   input  logic       I_RESET,
   input  logic       I_ENABLE,
   input  logic [3:0] I_LEN_LOAD,
   input  logic [7:0] I_LEN_DATA,
   input  logic [3:0] I_TRIGGER,
   input  logic [3:0] I_LEN_EN,
   output logic [2:0] O_STEP,
   output logic       O_LENGTH_TICK,
   output logic       O_SWEEP_TICK,
   output logic       O_ENV_TICK,
   output logic [3:0] O_LEN_ACTIVE
);
   localparam logic [15:0] LAST = 16'(DIVIDER - 1);
   logic [15:0] presc;
   logic [8:0]  cnt [4];
   logic        step_edge;
   assign step_edge = presc == LAST;
   always_ff @(posedge I_CLK) begin
      if (I_RESET || !I_ENABLE) begin
         presc         <= '0;
         O_STEP        <= '0;
         O_LENGTH_TICK <= 1'b0;
         O_SWEEP_TICK  <= 1'b0;
         O_ENV_TICK    <= 1'b0;
         O_LEN_ACTIVE  <= '0;
         for (int n = 0; n < 4; n++) cnt[n] <= '0;
      end else begin
         presc         <= step_edge ? '0 : presc + 16'd1;
         O_STEP        <= step_edge ? O_STEP + 3'd1 : O_STEP;
         O_LENGTH_TICK <= step_edge && !O_STEP[0];
         O_SWEEP_TICK  <= step_edge && O_STEP[1:0] == 2'd2;
         O_ENV_TICK    <= step_edge && O_STEP == 3'd7;
         // Load beats trigger beats decrement; any strobe suppresses the decrement.
         for (int n = 0; n < 4; n++) begin
            if (I_LEN_LOAD[n])
               cnt[n] <= n == 2 ? 9'd256 - {1'b0, I_LEN_DATA} : 9'd64 - {3'b0, I_LEN_DATA[5:0]};
            else if (I_TRIGGER[n]) begin
               if (cnt[n] == '0) cnt[n] <= n == 2 ? 9'd256 : 9'd64;
            end else if (O_LENGTH_TICK && I_LEN_EN[n] && cnt[n] != '0) begin
               cnt[n] <= cnt[n] - 9'd1;
               if (cnt[n] == 9'd1) O_LEN_ACTIVE[n] <= 1'b0;
            end
            if (I_TRIGGER[n]) O_LEN_ACTIVE[n] <= 1'b1;
         end
      end
   end
endmodule
